// File: rtl/div_clk_checker.sv
// Divided-clock waveform checker: measures div_in high/low runs, locks after LOCK_CNT good periods.
// All outputs registered, one clk after the causing edge/event; no backpressure (div_in free-running).
module div_clk_checker #(
  parameter int EXP_HIGH = 2,
  parameter int EXP_LOW  = 1,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 8,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic             tick,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       hi_len,
  output logic [3:0]       lo_len
);

  localparam int          GW        = $clog2(LOCK_CNT + 1);
  localparam logic [3:0]  EXP_HI_L  = 4'(EXP_HIGH);
  localparam logic [3:0]  EXP_LO_L  = 4'(EXP_LOW);
  localparam logic [3:0]  TIMEOUT_L = 4'(TIMEOUT);
  localparam logic [GW-1:0] LOCK_L  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, CHECK, LOCKED} state_t;

  state_t        state, state_nxt;
  logic          div_q;
  logic [3:0]    run_cnt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic          rise, fall, stuck, err, hi_ld, lo_ld;

  assign rise  = div_in & ~div_q;
  assign fall  = ~div_in & div_q;
  // run_cnt already holds the full length of the run that an edge terminates
  assign stuck = (run_cnt == TIMEOUT_L) && !(rise || fall);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err       = 1'b0;
    hi_ld     = 1'b0;
    lo_ld     = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      good_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
        ACQUIRE: begin
          if (rise) state_nxt = CHECK;
        end
        CHECK, LOCKED: begin
          hi_ld = fall;
          lo_ld = rise;
          if ((fall && run_cnt != EXP_HI_L) || (rise && run_cnt != EXP_LO_L) || stuck) begin
            err       = 1'b1;
            state_nxt = ACQUIRE;
            good_nxt  = '0;
          end else if (rise && state == CHECK) begin
            good_nxt = good_cnt + 1'b1;
            if (good_nxt == LOCK_L) state_nxt = LOCKED;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_q     <= 1'b0;
      run_cnt   <= '0;
      good_cnt  <= '0;
      tick      <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      hi_len    <= '0;
      lo_len    <= '0;
    end else begin
      state     <= state_nxt;
      div_q     <= div_in;
      good_cnt  <= good_nxt;
      tick      <= rise & en;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err;
      if (rise || fall)
        run_cnt <= 4'd1;
      else if (run_cnt != 4'hf)
        run_cnt <= run_cnt + 4'd1;
      if (err && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
      if (hi_ld) hi_len <= run_cnt;
      if (lo_ld) lo_len <= run_cnt;
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker: lock, bad high run, stuck, en drop, async reset, saturation.
module tb_div_clk_checker;

  logic       clk = 1'b0;
  logic       rst, en, div_in;
  logic       tick, locked, err_pulse;
  logic [7:0] err_cnt;
  logic [3:0] hi_len, lo_len;
  logic       s_tick, s_locked, s_err_pulse;
  logic [1:0] s_err_cnt;
  logic [3:0] s_hi_len, s_lo_len;
  int         checks = 0;
  int         errors = 0;
  int         pulses;

  always #5 clk = ~clk;

  div_clk_checker u_dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in),
    .tick(tick), .locked(locked), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .hi_len(hi_len), .lo_len(lo_len)
  );

  div_clk_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in),
    .tick(s_tick), .locked(s_locked), .err_pulse(s_err_pulse),
    .err_cnt(s_err_cnt), .hi_len(s_hi_len), .lo_len(s_lo_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one div_in sample; return just after the edge that samples it.
  task automatic step(input logic d);
    div_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic periods(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1);
      step(1'b1);
      step(1'b0);
    end
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    div_in = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_hi_len", 32'(hi_len), 0);
    chk("rst_lo_len", 32'(lo_len), 0);

    // Lock on 110 repeating: 1st rise enters CHECK, 5th rise completes 4th good period
    rst = 1'b1;
    en  = 1'b1;
    step(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      chk("lock_tick_rise", 32'(tick), 1);
      chk("lock_locked", 32'(locked), 32'(k == 4));
      step(1'b1);
      chk("lock_tick_hi", 32'(tick), 0);
      step(1'b0);
      chk("lock_tick_lo", 32'(tick), 0);
    end
    chk("lock_hi_len", 32'(hi_len), 2);
    chk("lock_lo_len", 32'(lo_len), 1);
    chk("lock_err_cnt", 32'(err_cnt), 0);

    // One 1110 period while locked
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("bad_pre_pulse", 32'(err_pulse), 0);
    chk("bad_pre_locked", 32'(locked), 1);
    step(1'b0);
    chk("bad_err_pulse", 32'(err_pulse), 1);
    chk("bad_err_cnt", 32'(err_cnt), 1);
    chk("bad_locked", 32'(locked), 0);
    chk("bad_hi_len", 32'(hi_len), 3);
    step(1'b1);
    chk("bad_pulse_once", 32'(err_pulse), 0);
    chk("bad_tick", 32'(tick), 1);
    step(1'b1);
    step(1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      chk("relock_locked", 32'(locked), 32'(k == 3));
      step(1'b1);
      step(1'b0);
    end
    chk("relock_err_cnt", 32'(err_cnt), 1);

    // Stuck high for 20 samples after a rise while locked
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk("stuck_pulse", 32'(err_pulse), 32'(i == 8));
      chk("stuck_locked", 32'(locked), 32'(i < 8));
      if (err_pulse === 1'b1) pulses++;
    end
    chk("stuck_pulse_total", 32'(pulses), 1);
    chk("stuck_err_cnt", 32'(err_cnt), 2);

    // Relock, then drop en on the same cycle as a bad (3-long) high run ends
    step(1'b0);
    periods(5);
    chk("relock2_locked", 32'(locked), 1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    en = 1'b0;
    step(1'b0);
    chk("en_locked", 32'(locked), 0);
    chk("en_err_pulse", 32'(err_pulse), 0);
    chk("en_err_cnt", 32'(err_cnt), 2);
    chk("en_hi_len", 32'(hi_len), 2);
    chk("en_lo_len", 32'(lo_len), 1);
    step(1'b1);
    chk("en_tick_gated", 32'(tick), 0);

    // Relock, then assert reset mid-cycle with no clock edge
    en = 1'b1;
    step(1'b0);
    periods(5);
    chk("relock3_locked", 32'(locked), 1);
    chk("relock3_err_cnt", 32'(err_cnt), 2);
    chk("sat_pre_err_cnt", 32'(s_err_cnt), 2);
    step(1'b1);
    chk("pre_arst_tick", 32'(tick), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    chk("arst_hi_len", 32'(hi_len), 0);
    chk("arst_lo_len", 32'(lo_len), 0);
    chk("arst_s_tick", 32'(s_tick), 0);
    chk("arst_s_locked", 32'(s_locked), 0);
    chk("arst_s_err_cnt", 32'(s_err_cnt), 0);
    chk("arst_s_hi_len", 32'(s_hi_len), 0);
    chk("arst_s_lo_len", 32'(s_lo_len), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Repeated 1110 periods: 2-bit counter saturates at 3, pulses continue
    step(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      chk("sat_err_pulse", 32'(s_err_pulse), 1);
      chk("sat_err_cnt", 32'(s_err_cnt), 32'((k + 1 > 3) ? 3 : k + 1));
      chk("sat_wide_err_cnt", 32'(err_cnt), 32'(k + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_clk_checker.md
DIV_CLK_CHECKER -- requirements
Module: div_clk_checker

Interface
REQ-001 The block SHALL have parameter EXP_HIGH, default 2: expected high run of div_in, in clk cycles.
REQ-002 The block SHALL have parameter EXP_LOW, default 1: expected low run of div_in, in clk cycles.
REQ-003 The block SHALL have parameter LOCK_CNT, default 4: consecutive good periods required to assert locked.
REQ-004 The block SHALL have parameter TIMEOUT, default 8: run length, in cycles, at which div_in is declared stuck.
REQ-005 The block SHALL have parameter ERR_W, default 8: width of err_cnt.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port en, input, 1 bit: checking enable.
REQ-009 The block SHALL have port div_in, input, 1 bit: divided clock from the upstream divide-by-3 stage, synchronous to clk.
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle clock-enable pulse per div_in rising edge.
REQ-011 The block SHALL have port locked, output, 1 bit: div_in waveform is verified good.
REQ-012 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse per detected error.
REQ-013 The block SHALL have port err_cnt, output, ERR_W bits: saturating error count.
REQ-014 The block SHALL have port hi_len and port lo_len, outputs, 4 bits each: last measured high and low run lengths.

Function
REQ-015 Edge detection: the block SHALL register div_in as div_q; rise is div_in=1 with div_q=0; fall is div_in=0 with div_q=1.
REQ-016 Run counter: the block SHALL set it to 1 on any edge, otherwise increment it, saturating at 15; a run length is the number of consecutive samples at one level.
REQ-017 Outputs: tick, err_pulse, locked, hi_len and lo_len SHALL be registered, updating the cycle after the edge or event that causes them.
REQ-018 tick SHALL pulse on every rise while en=1, regardless of state or lock.
REQ-019 States: the FSM SHALL have IDLE, ACQUIRE, CHECK and LOCKED.
REQ-020 IDLE (en=0 or reset) SHALL go to ACQUIRE when en=1.
REQ-021 ACQUIRE SHALL ignore partial runs and go to CHECK on the first rise.
REQ-022 In CHECK or LOCKED, a fall SHALL latch hi_len; a high run not equal to EXP_HIGH SHALL be an error.
REQ-023 In CHECK or LOCKED, a rise SHALL latch lo_len; a low run not equal to EXP_LOW SHALL be an error; otherwise the period is good and the good counter increments.
REQ-024 CHECK SHALL go to LOCKED when the good counter reaches LOCK_CNT, and locked SHALL assert in the same cycle.
REQ-025 Any error in CHECK or LOCKED SHALL produce one err_pulse, increment err_cnt saturating at 2^ERR_W-1, clear the good counter, deassert locked, and go to ACQUIRE.
REQ-026 Stuck: in CHECK or LOCKED, the run counter reaching exactly TIMEOUT without an edge SHALL be one error per episode; staying stuck SHALL NOT produce further pulses.
REQ-027 en falling: the block SHALL go to IDLE next cycle, clear locked and the good counter, and hold err_cnt, hi_len and lo_len.
REQ-028 Simultaneous en falling and error: en SHALL win; no err_pulse, err_cnt unchanged.

Reset
REQ-029 rst=0 SHALL immediately force IDLE and clear div_q, the run counter, the good counter, tick, locked, err_pulse, err_cnt, hi_len and lo_len to 0, independent of clk.
REQ-030 After rst rises, the first rise of div_in SHALL NOT be counted as an edge unless div_in was sampled 0 beforehand (div_q is reset to 0).

Verification
REQ-031 Lock: rst release, en=1, div_in=110 repeating -> tick every 3 cycles, locked=1 after the 4th good period's rise, err_cnt=0, hi_len=2, lo_len=1.
REQ-032 Bad high run: from locked, one period 1110 -> err_pulse one cycle after that fall, err_cnt=1, locked=0, hi_len=3; relocks after 4 good periods.
REQ-033 Stuck: from locked, div_in held 1 for 20 cycles -> exactly one err_pulse, 8 cycles after the last rise (+1 register), err_cnt=1.
REQ-034 Saturation: ERR_W=2 with repeated bad periods -> err_cnt stops at 3 while err_pulse continues.
REQ-035 Reset and en mid-operation: rst=0 while locked -> all outputs 0 asynchronously; en=0 while locked -> locked=0 next cycle, err_cnt held, no err_pulse.
